addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined adder/subtractor.
- Result is A + B when op=0, or A - B when op=1 (two's complement: B inverted, carry-in = op).
- Sums CHUNK bits per stage and passes the carry stage to stage, giving a configurable WIDTH with one result per cycle.
- Sits between the register-file read stage and writeback/flag logic; has valid/ready handshakes on both sides and produces sf/cf/of/zf flags.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits summed per pipeline stage; STAGES = WIDTH/CHUNK (1..WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands A, B and op are valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- op  input  1  0 = add, 1 = subtract.
- out_valid  output  1  sum and flags are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- sf  output  1  sign flag, sum[WIDTH-1].
- cf  output  1  raw carry out of MSB. For subtract, 1 = no borrow.
- of  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zf  output  1  1 when sum == 0.

Behaviour:
- Reset: sampled on the clk edge when rst_n=0.
  - Clears every stage valid bit.
  - out_valid=0, sum=0, sf=cf=of=zf=0.
  - Reset mid-operation discards all in-flight operations; no partial result is ever presented.
- Datapath:
  - Stage k (k=0..STAGES-1) registers chunk k of the sum, its carry-out, and the not-yet-summed upper operand bits.
  - Stage 0 uses carry-in = op and B XOR {WIDTH{op}}.
  - Stage k>0 uses the carry registered by stage k-1.
  - The last stage also registers the carry into the MSB, used for of.
  - The output register is the last stage.
- Stall rule:
  - advance = ~out_valid | out_ready.
  - in_ready = advance, a combinational function of out_valid and out_ready only, never of in_valid.
  - When advance=1, every stage loads from its predecessor, and stage 0 loads in_valid/A/B/op.
  - When advance=0, all stages hold their contents, including bubbles.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Output data and flags are stable while out_valid=1 and out_ready=0.
- Latency: STAGES cycles from input transfer to out_valid, with no stall.
- Throughput: 1 operation per cycle when out_ready is held at 1. Order is preserved.
- Bubbles: an invalid slot (in_valid=0) propagates as a bubble; its data contents are don't-care but must not raise out_valid.
- Simultaneous events: output transfer and input transfer in the same cycle are both legal, and the pipeline shifts by one.
- Wrap-around: sum is modulo 2^WIDTH.
  - 0xFFFFFFFF+1 gives sum=0, cf=1, of=0, zf=1.
  - 0x7FFFFFFF+1 gives sum=0x80000000, of=1, sf=1, cf=0.
- STAGES=1 degenerates to a single-register adder with latency 1.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: adds input port sat (1 bit), captured with the operands.
  - When sat=1 and of=1, sum is clamped to the signed limit: 0x7FF..F if the true result is positive (sign of A = 0), 0x800..0 if negative.
  - Flags are computed on the unclamped result, except zf and sf, which reflect the clamped sum.
  - When sat=0, behaviour is identical to the undefined build.
- Undefined: no sat port; results always wrap.

Test Plan:
- Reset, then add 0x00000005+0x00000003 (WIDTH=32, CHUNK=8), out_ready=1 -> out_valid rises exactly 4 cycles after transfer; sum=0x00000008, sf=cf=of=zf=0.
- Subtract 0x00000003-0x00000005 -> sum=0xFFFFFFFE, sf=1, cf=0 (borrow), of=0, zf=0. Then 5-5 -> sum=0, zf=1, cf=1.
- Carry across every chunk boundary: 0x00FFFFFF+0x00000001 -> 0x01000000. Then 0x7FFFFFFF+1 -> of=1, sf=1. Then 0x80000000-1 -> 0x7FFFFFFF, of=1.
- Back-to-back stream of 10 operations with out_ready=1 -> 10 results on 10 consecutive cycles, in order. Then hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, outputs stable, no loss or duplication.
- Pull rst_n low for one cycle with 3 operations in flight -> next cycle out_valid=0 and all outputs zero; none of the 3 results ever appears.
- ADDSUB_SAT_EN build, sat=1: 0x7FFFFFFF+0x00000010 -> sum=0x7FFFFFFF, of=1. 0x80000000-1 -> sum=0x80000000. Same operands with sat=0 -> wrapped results.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: CHUNK bits per stage, carry rippled stage to stage.
// Optional saturation on signed overflow when ADDSUB_SAT_EN is defined.
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             sf,
  output logic             cf,
  output logic             of,
  output logic             zf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;
  assign w_bx     = B ^ {WIDTH{op}};

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int  IW   = WIDTH - k * CHUNK;
    localparam int  SW   = (k + 1) * CHUNK;
    localparam bit  LAST = (k == STAGES - 1);

    logic [IW-1:0]    w_ina;
    logic [IW-1:0]    w_inb;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_cin;
    logic             w_vin;
    logic [CHUNK:0]   w_add;
    logic [SW-1:0]    w_snext;
    logic [SW-1:0]    w_sload;
`ifdef ADDSUB_SAT_EN
    logic             w_sat_in;
`endif

    logic             r_v;
    logic [SW-1:0]    r_s;
    logic             r_c;

    if (k == 0) begin : g_head
      assign w_ina   = A;
      assign w_inb   = w_bx;
      assign w_cin   = op;
      assign w_vin   = in_valid;
      assign w_snext = w_add[CHUNK-1:0];
`ifdef ADDSUB_SAT_EN
      assign w_sat_in = sat;
`endif
    end else begin : g_body
      assign w_ina   = g_st[k-1].g_pass.r_a;
      assign w_inb   = g_st[k-1].g_pass.r_b;
      assign w_cin   = g_st[k-1].r_c;
      assign w_vin   = g_st[k-1].r_v;
      assign w_snext = {w_add[CHUNK-1:0], g_st[k-1].r_s};
`ifdef ADDSUB_SAT_EN
      assign w_sat_in = g_st[k-1].g_pass.r_sat;
`endif
    end

    assign w_ca  = w_ina[CHUNK-1:0];
    assign w_cb  = w_inb[CHUNK-1:0];
    assign w_add = {1'b0, w_ca} + {1'b0, w_cb}
                 + {{CHUNK{1'b0}}, w_cin};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_s <= '0;
        r_c <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_vin;
        r_s <= w_sload;
        r_c <= w_add[CHUNK];
      end
    end

    if (!LAST) begin : g_pass
      localparam int RW = IW - CHUNK;
      logic [RW-1:0] r_a;
      logic [RW-1:0] r_b;
`ifdef ADDSUB_SAT_EN
      logic          r_sat;
`endif

      assign w_sload = w_snext;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
`ifdef ADDSUB_SAT_EN
          r_sat <= 1'b0;
`endif
        end else if (w_adv) begin
          r_a <= w_ina[IW-1:CHUNK];
          r_b <= w_inb[IW-1:CHUNK];
`ifdef ADDSUB_SAT_EN
          r_sat <= w_sat_in;
`endif
        end
      end
    end else begin : g_tail
      logic w_cmsb;
      logic w_of;
      logic r_of;
      logic r_sf;
      logic r_zf;

      // Carry into the MSB recovered from the MSB sum bit.
      assign w_cmsb = w_add[CHUNK-1] ^ w_ca[CHUNK-1] ^ w_cb[CHUNK-1];
      assign w_of   = w_cmsb ^ w_add[CHUNK];

`ifdef ADDSUB_SAT_EN
      logic w_clamp;
      assign w_clamp = w_sat_in & w_of;
      assign w_sload = w_clamp
        ? {w_ca[CHUNK-1], {(WIDTH-1){~w_ca[CHUNK-1]}}}
        : w_snext;
`else
      assign w_sload = w_snext;
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_of <= 1'b0;
          r_sf <= 1'b0;
          r_zf <= 1'b0;
        end else if (w_adv) begin
          r_of <= w_of;
          r_sf <= w_sload[WIDTH-1];
          r_zf <= (w_sload == '0);
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].r_v;
  assign sum       = g_st[STAGES-1].r_s;
  assign cf        = g_st[STAGES-1].r_c;
  assign of        = g_st[STAGES-1].g_tail.r_of;
  assign sf        = g_st[STAGES-1].g_tail.r_sf;
  assign zf        = g_st[STAGES-1].g_tail.r_zf;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: scoreboard against an arithmetic model.
// Covers directed corner cases, streaming, stalls, reset flush, random.
module tb_addsub_pipe;
  localparam int W = 32;
  localparam int C = 8;
  localparam int S = W / C;

  typedef struct packed {
    logic [W-1:0] s;
    logic sf;
    logic cf;
    logic of;
    logic zf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic op = 1'b0;
  logic sat = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] sum;
  logic sf, cf, of, zf;

  int checks = 0;
  int failures = 0;
  res_t q[$];
  bit rnd_ready = 0;

  addsub_pipe #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op),
`ifdef ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .sf(sf), .cf(cf), .of(of), .zf(zf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic o, input logic st);
    res_t r;
    longint sa, sb, sr, mx, mn;
    longint ua, ub, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = o ? sa - sb : sa + sb;
    mx = (longint'(1) <<< (W - 1)) - 1;
    mn = -(longint'(1) <<< (W - 1));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    // Raw carry: add carries past 2^W; subtract carries when no borrow.
    ur = o ? ua + (longint'(1) <<< W) - ub : ua + ub;
    r.s  = ur[W-1:0];
    r.cf = ur[W];
    r.of = (sr > mx) || (sr < mn);
`ifndef ADDSUB_SAT_EN
    st = 1'b0;
`endif
    if (st && r.of) begin
      if (sr > 0) r.s = mx[W-1:0];
      else        r.s = mn[W-1:0];
    end
    r.sf = r.s[W-1];
    r.zf = (r.s == '0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("result", 64'({sum, sf, cf, of, zf}), 64'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(A, B, op, sat));
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic o, input logic st);
    int t;
    t = 0;
    A = a; B = b; op = o; sat = st;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (S + 1) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic count_run(input int exp);
    int t, run;
    t = 0;
    run = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    while (out_valid && run < 40) begin
      run++;
      @(negedge clk);
    end
    chk("consecutive_run", 64'(run), 64'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    res_t m;
    int n;
    logic [W-1:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", 64'({out_valid, sum, sf, cf, of, zf}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    m = model(32'h5, 32'h3, 1'b0, 1'b0);
    chk("pin_add", 64'(m), 64'({32'h8, 4'b0000}));
    m = model(32'h3, 32'h5, 1'b1, 1'b0);
    chk("pin_sub_neg", 64'(m), 64'({32'hFFFFFFFE, 4'b1000}));
    m = model(32'h5, 32'h5, 1'b1, 1'b0);
    chk("pin_sub_zero", 64'(m), 64'({32'h0, 4'b0101}));
    m = model(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
    chk("pin_wrap", 64'(m), 64'({32'h0, 4'b0101}));
    m = model(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
    chk("pin_ovf_pos", 64'(m), 64'({32'h80000000, 4'b1010}));
    m = model(32'h80000000, 32'h1, 1'b1, 1'b0);
    chk("pin_ovf_neg", 64'(m), 64'({32'h7FFFFFFF, 4'b0110}));
`ifdef ADDSUB_SAT_EN
    m = model(32'h7FFFFFFF, 32'h10, 1'b0, 1'b1);
    chk("pin_sat_pos", 64'(m), 64'({32'h7FFFFFFF, 4'b0010}));
    m = model(32'h80000000, 32'h1, 1'b1, 1'b1);
    chk("pin_sat_neg", 64'(m), 64'({32'h80000000, 4'b1110}));
`endif

    out_ready = 1'b1;
    send(32'h5, 32'h3, 1'b0, 1'b0);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(S));
    chk("first_sum", 64'({sum, sf, cf, of, zf}), 64'({32'h8, 4'b0000}));
    @(posedge clk);
    #1;

    send(32'h3, 32'h5, 1'b1, 1'b0);
    send(32'h5, 32'h5, 1'b1, 1'b0);
    send(32'h00FFFFFF, 32'h1, 1'b0, 1'b0);
    send(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
    send(32'h80000000, 32'h1, 1'b1, 1'b0);
    send(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
    drain();

    fork
      for (int i = 0; i < 10; i++)
        send($urandom, $urandom, 1'($urandom), 1'b0);
      count_run(10);
    join
    drain();

    fork
      for (int i = 0; i < 10; i++)
        send($urandom, $urandom, 1'($urandom), 1'b0);
      begin
        repeat (S + 2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++)
      send(32'h100 + 32'(i), 32'h1, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("flush_state", 64'({out_valid, sum, sf, cf, of, zf}), 64'd0);
    repeat (S + 4) @(posedge clk);
    #1;

`ifdef ADDSUB_SAT_EN
    send(32'h7FFFFFFF, 32'h10, 1'b0, 1'b1);
    send(32'h80000000, 32'h1, 1'b1, 1'b1);
    send(32'h7FFFFFFF, 32'h10, 1'b0, 1'b0);
    send(32'h80000000, 32'h1, 1'b1, 1'b0);
    drain();
`endif

    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h7FFFFFFF;
        1: ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      send(ra, rb, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_ready = 0;
    @(posedge clk);
    #2;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
